vdp_super_res_writer: RTL and testbench

VDP_SUPER_RES_WRITER -- requirements
Module: vdp_super_res_writer

---
 rtl/vdp_super_res_writer.sv | 175 +++++++++++++++++
 tb/tb_vdp_super_res_writer.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vdp_super_res_writer.sv
// Super-res pixel writer: queues pixel write requests and turns each one into a
// VRAM byte write, with a read-modify-write for 4bpp packed pixels.
package vdp_super_res_writer_pkg;
    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
        logic [7:0] data;
    } wr_req_t;
endpackage

module vdp_super_res_writer
    import vdp_super_res_writer_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        vdp_super,
    input  logic        super_res,
    input  logic        super_mid,
    input  logic        ext_reg_pixel_depth,
    input  logic [16:0] ext_reg_super_res_page_addr,
    input  logic        super_res_drawing,
    input  logic        wr_valid,
    output logic        wr_ready,
    input  logic [9:0]  wr_x,
    input  logic [9:0]  wr_y,
    input  logic [7:0]  wr_data,
    output logic [17:0] vram_addr,
    output logic        vram_rd,
    output logic        vram_wr,
    output logic [7:0]  vram_wdata,
    input  logic [7:0]  vram_rdata,
    input  logic        vram_ack,
    output logic        busy
);

    localparam int unsigned PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W  = PTR_W + 1;
    localparam int unsigned OFF_W  = 19;
    localparam int unsigned ADDR_W = 18;

    typedef enum logic [2:0] {
        IDLE,
        CALC,
        READ,
        MERGE,
        WRITE
    } state_t;

    state_t             state;
    wr_req_t            mem [FIFO_DEPTH];
    wr_req_t            cur;
    logic [PTR_W-1:0]   wptr;
    logic [PTR_W-1:0]   rptr;
    logic [CNT_W-1:0]   count;
    logic [7:0]         rdata_q;
    logic               fifo_full;
    logic               fifo_empty;
    logic               push;
    logic               pop;
    logic [OFF_W-1:0]   y_ext;
    logic [OFF_W-1:0]   row_off;
    logic [OFF_W-1:0]   pix_off;
    logic [OFF_W-1:0]   byte_off;
    logic [ADDR_W-1:0]  base_addr;
    logic [ADDR_W-1:0]  calc_addr;
    logic               unused_mode;

    // Width only distinguishes 720 from 360, so mid mode needs no separate term.
    assign unused_mode = super_mid;

    assign fifo_full  = (count == CNT_W'(FIFO_DEPTH));
    assign fifo_empty = (count == '0);
    assign wr_ready   = reset_n & vdp_super & ~fifo_full;
    assign push       = wr_valid & wr_ready;
    assign pop        = (state == IDLE) & ~fifo_empty & ~super_res_drawing;
    assign busy       = ~fifo_empty | (state != IDLE);

    // Row offset by shift-add: 720 = 512+128+64+16, 360 = 256+64+32+8.
    always_comb begin
        y_ext = OFF_W'(cur.y);
        if (super_res) begin
            row_off = (y_ext << 9) + (y_ext << 7) + (y_ext << 6) + (y_ext << 4);
        end else begin
            row_off = (y_ext << 8) + (y_ext << 6) + (y_ext << 5) + (y_ext << 3);
        end
        pix_off   = row_off + OFF_W'(cur.x);
        byte_off  = ext_reg_pixel_depth ? (pix_off >> 1) : pix_off;
        base_addr = {ext_reg_super_res_page_addr, 1'b0};
        calc_addr = base_addr + ADDR_W'(byte_off);
    end

    // Request storage; payload needs no reset since count gates validity.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wptr] <= '{x: wr_x, y: wr_y, data: wr_data};
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            wptr       <= '0;
            rptr       <= '0;
            count      <= '0;
            cur        <= '0;
            rdata_q    <= '0;
            vram_addr  <= '0;
            vram_wdata <= '0;
            vram_rd    <= 1'b0;
            vram_wr    <= 1'b0;
        end else if (!vdp_super) begin
            // Disable flushes the queue and abandons any bus cycle in progress.
            state   <= IDLE;
            wptr    <= '0;
            rptr    <= '0;
            count   <= '0;
            vram_rd <= 1'b0;
            vram_wr <= 1'b0;
        end else begin
            if (push) begin
                wptr <= wptr + PTR_W'(1);
            end
            if (pop) begin
                rptr <= rptr + PTR_W'(1);
            end
            count <= count + CNT_W'(push) - CNT_W'(pop);

            case (state)
                IDLE: begin
                    if (pop) begin
                        cur   <= mem[rptr];
                        state <= CALC;
                    end
                end
                CALC: begin
                    vram_addr <= calc_addr;
                    if (ext_reg_pixel_depth) begin
                        vram_rd <= 1'b1;
                        state   <= READ;
                    end else begin
                        vram_wdata <= cur.data;
                        vram_wr    <= 1'b1;
                        state      <= WRITE;
                    end
                end
                READ: begin
                    if (vram_ack) begin
                        rdata_q <= vram_rdata;
                        vram_rd <= 1'b0;
                        state   <= MERGE;
                    end
                end
                MERGE: begin
                    // Even x owns the high nibble, odd x the low nibble.
                    vram_wdata <= cur.x[0] ? {rdata_q[7:4], cur.data[3:0]}
                                           : {cur.data[3:0], rdata_q[3:0]};
                    vram_wr    <= 1'b1;
                    state      <= WRITE;
                end
                WRITE: begin
                    if (vram_ack) begin
                        vram_wr <= 1'b0;
                        state   <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vdp_super_res_writer.sv
// Directed bench for vdp_super_res_writer with a small acking VRAM responder.
module tb_vdp_super_res_writer;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic        vdp_super;
    logic        super_res;
    logic        super_mid;
    logic        ext_reg_pixel_depth;
    logic [16:0] ext_reg_super_res_page_addr;
    logic        super_res_drawing;
    logic        wr_valid;
    logic        wr_ready;
    logic [9:0]  wr_x;
    logic [9:0]  wr_y;
    logic [7:0]  wr_data;
    logic [17:0] vram_addr;
    logic        vram_rd;
    logic        vram_wr;
    logic [7:0]  vram_wdata;
    logic [7:0]  vram_rdata;
    logic        vram_ack = 1'b0;
    logic        busy;

    int checks = 0;
    int failures = 0;

    // Responder state and transaction log
    int          ack_delay = 1;
    int          wait_cnt = 0;
    int          n_rd = 0;
    int          n_wr = 0;
    int          strobe_cycles = 0;
    int          both_cnt = 0;
    logic [17:0] last_rd_addr = '0;
    logic [17:0] wa_q [$];
    logic [7:0]  wd_q [$];

    vdp_super_res_writer #(.FIFO_DEPTH(4)) dut (
        .clk                         (clk),
        .reset_n                     (reset_n),
        .vdp_super                   (vdp_super),
        .super_res                   (super_res),
        .super_mid                   (super_mid),
        .ext_reg_pixel_depth         (ext_reg_pixel_depth),
        .ext_reg_super_res_page_addr (ext_reg_super_res_page_addr),
        .super_res_drawing           (super_res_drawing),
        .wr_valid                    (wr_valid),
        .wr_ready                    (wr_ready),
        .wr_x                        (wr_x),
        .wr_y                        (wr_y),
        .wr_data                     (wr_data),
        .vram_addr                   (vram_addr),
        .vram_rd                     (vram_rd),
        .vram_wr                     (vram_wr),
        .vram_wdata                  (vram_wdata),
        .vram_rdata                  (vram_rdata),
        .vram_ack                    (vram_ack),
        .busy                        (busy)
    );

    always #5 clk = ~clk;

    // VRAM responder: acks a strobe after ack_delay cycles and logs the access.
    always @(posedge clk) begin
        #2;
        if (vram_rd && vram_wr) both_cnt++;
        if (vram_rd || vram_wr) strobe_cycles++;
        if ((vram_rd || vram_wr) && !vram_ack) begin
            if (wait_cnt >= ack_delay) begin
                vram_ack = 1'b1;
                wait_cnt = 0;
                if (vram_rd) begin
                    n_rd++;
                    last_rd_addr = vram_addr;
                end else begin
                    n_wr++;
                    wa_q.push_back(vram_addr);
                    wd_q.push_back(vram_wdata);
                end
            end else begin
                wait_cnt++;
            end
        end else begin
            vram_ack = 1'b0;
            wait_cnt = 0;
        end
    end

    task automatic push_req(input logic [9:0] x, input logic [9:0] y, input logic [7:0] d);
        checks++;
        if (wr_ready !== 1'b1) begin
            failures++;
            $display("FAIL push_ready: wr_ready=%0b expected 1", wr_ready);
        end
        wr_x = x; wr_y = y; wr_data = d; wr_valid = 1'b1;
        @(posedge clk); #1;
        wr_valid = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while ((busy || vram_rd || vram_wr) && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL %s_timeout: busy=%0b expected 0", name, busy);
        end
    endtask

    task automatic test_reset();
        #1 reset_n = 1'b0;
        #1;
        checks += 6;
        if (wr_ready !== 1'b0)   begin failures++; $display("FAIL rst_ready: got %0b expected 0", wr_ready); end
        if (vram_rd !== 1'b0)    begin failures++; $display("FAIL rst_rd: got %0b expected 0", vram_rd); end
        if (vram_wr !== 1'b0)    begin failures++; $display("FAIL rst_wr: got %0b expected 0", vram_wr); end
        if (busy !== 1'b0)       begin failures++; $display("FAIL rst_busy: got %0b expected 0", busy); end
        if (vram_addr !== 18'h0) begin failures++; $display("FAIL rst_addr: got %h expected 0", vram_addr); end
        if (vram_wdata !== 8'h0) begin failures++; $display("FAIL rst_wdata: got %h expected 0", vram_wdata); end
        repeat (2) @(posedge clk);
        #3 reset_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (wr_ready !== 1'b1) begin failures++; $display("FAIL rst_release_ready: got %0b expected 1", wr_ready); end
    endtask

    task automatic test_8bpp();
        int b_rd = n_rd;
        int b_wr = n_wr;
        super_res = 1'b1; super_mid = 1'b0; ext_reg_pixel_depth = 1'b0;
        ext_reg_super_res_page_addr = 17'h00100;
        push_req(10'd10, 10'd2, 8'h3C);
        @(posedge clk); #1;
        checks++;
        if (vram_wr !== 1'b0) begin failures++; $display("FAIL lat8_n1: vram_wr=%0b expected 0", vram_wr); end
        @(posedge clk); #1;
        checks += 3;
        if (vram_wr !== 1'b1)      begin failures++; $display("FAIL lat8_n2: vram_wr=%0b expected 1", vram_wr); end
        if (vram_addr !== 18'h007AA) begin failures++; $display("FAIL addr8: got %h expected 007aa", vram_addr); end
        if (vram_wdata !== 8'h3C)  begin failures++; $display("FAIL wdata8: got %h expected 3c", vram_wdata); end
        wait_idle("8bpp");
        checks += 2;
        if (n_rd - b_rd !== 0) begin failures++; $display("FAIL rd8_count: got %0d expected 0", n_rd - b_rd); end
        if (n_wr - b_wr !== 1) begin failures++; $display("FAIL wr8_count: got %0d expected 1", n_wr - b_wr); end
    endtask

    task automatic test_4bpp_rmw();
        int b_rd = n_rd;
        int b_wr = n_wr;
        super_res = 1'b1; ext_reg_pixel_depth = 1'b1;
        ext_reg_super_res_page_addr = 17'h0;
        vram_rdata = 8'hAB;
        push_req(10'd11, 10'd1, 8'h05);
        @(posedge clk); #1;
        @(posedge clk); #1;
        checks++;
        if (vram_rd !== 1'b1) begin failures++; $display("FAIL lat4_n2: vram_rd=%0b expected 1", vram_rd); end
        wait_idle("rmw_odd");
        checks += 4;
        if (n_rd - b_rd !== 1)            begin failures++; $display("FAIL rmw_rd_count: got %0d expected 1", n_rd - b_rd); end
        if (last_rd_addr !== 18'h0016D)   begin failures++; $display("FAIL rmw_rd_addr: got %h expected 0016d", last_rd_addr); end
        if (wa_q[b_wr] !== 18'h0016D)     begin failures++; $display("FAIL rmw_wr_addr: got %h expected 0016d", wa_q[b_wr]); end
        if (wd_q[b_wr] !== 8'hA5)         begin failures++; $display("FAIL rmw_odd_data: got %h expected a5", wd_q[b_wr]); end
        push_req(10'd10, 10'd1, 8'h05);
        wait_idle("rmw_even");
        checks += 2;
        if (wa_q[b_wr + 1] !== 18'h0016D) begin failures++; $display("FAIL rmw_even_addr: got %h expected 0016d", wa_q[b_wr + 1]); end
        if (wd_q[b_wr + 1] !== 8'h5B)     begin failures++; $display("FAIL rmw_even_data: got %h expected 5b", wd_q[b_wr + 1]); end
    endtask

    task automatic test_mid_wrap();
        int b_wr = n_wr;
        super_res = 1'b0; super_mid = 1'b1; ext_reg_pixel_depth = 1'b0;
        ext_reg_super_res_page_addr = 17'h0;
        push_req(10'd359, 10'd239, 8'h11);
        wait_idle("mid");
        super_res = 1'b1; super_mid = 1'b0;
        ext_reg_super_res_page_addr = 17'h1FFFF;
        push_req(10'd5, 10'd0, 8'h22);
        wait_idle("wrap");
        checks += 2;
        if (wa_q[b_wr] !== 18'h1517F)     begin failures++; $display("FAIL mid_addr: got %h expected 1517f", wa_q[b_wr]); end
        if (wa_q[b_wr + 1] !== 18'h00003) begin failures++; $display("FAIL wrap_addr: got %h expected 00003", wa_q[b_wr + 1]); end
    endtask

    task automatic test_blocking();
        int b_wr = n_wr;
        int b_strobe;
        logic accepted = 1'b0;
        super_res = 1'b1; ext_reg_pixel_depth = 1'b0;
        ext_reg_super_res_page_addr = 17'h0;
        super_res_drawing = 1'b1;
        b_strobe = strobe_cycles;
        for (int i = 0; i < 4; i++) push_req(10'(i), 10'd0, 8'(8'h10 + i));
        checks++;
        if (wr_ready !== 1'b0) begin failures++; $display("FAIL block_full_ready: got %0b expected 0", wr_ready); end
        repeat (10) @(posedge clk);
        #1;
        checks += 2;
        if (strobe_cycles !== b_strobe) begin failures++; $display("FAIL block_strobes: got %0d cycles expected 0", strobe_cycles - b_strobe); end
        if (busy !== 1'b1)              begin failures++; $display("FAIL block_busy: got %0b expected 1", busy); end
        wr_x = 10'd4; wr_y = 10'd0; wr_data = 8'h14; wr_valid = 1'b1;
        super_res_drawing = 1'b0;
        for (int i = 0; i < 50 && !accepted; i++) begin
            if (wr_ready) accepted = 1'b1;
            @(posedge clk); #1;
        end
        wr_valid = 1'b0;
        checks++;
        if (!accepted) begin failures++; $display("FAIL block_fifth_accept: accepted=0 expected 1"); end
        wait_idle("block");
        checks++;
        if (n_wr - b_wr !== 5) begin failures++; $display("FAIL block_wr_count: got %0d expected 5", n_wr - b_wr); end
        for (int i = 0; i < 5 && (b_wr + i) < n_wr; i++) begin
            checks += 2;
            if (wd_q[b_wr + i] !== 8'(8'h10 + i)) begin failures++; $display("FAIL block_order_data[%0d]: got %h expected %h", i, wd_q[b_wr + i], 8'(8'h10 + i)); end
            if (wa_q[b_wr + i] !== 18'(i))        begin failures++; $display("FAIL block_order_addr[%0d]: got %h expected %h", i, wa_q[b_wr + i], 18'(i)); end
        end
    endtask

    task automatic test_atomic();
        int b_rd = n_rd;
        int b_wr = n_wr;
        logic seen = 1'b0;
        super_res = 1'b1; ext_reg_pixel_depth = 1'b1;
        ext_reg_super_res_page_addr = 17'h0;
        vram_rdata = 8'h9E;
        push_req(10'd1, 10'd0, 8'h07);
        push_req(10'd2, 10'd0, 8'h0C);
        for (int i = 0; i < 40 && !seen; i++) begin
            @(posedge clk); #3;
            if (vram_rd && vram_ack) begin
                super_res_drawing = 1'b1;
                seen = 1'b1;
            end
        end
        checks++;
        if (!seen) begin failures++; $display("FAIL atomic_read_ack: seen=0 expected 1"); end
        for (int i = 0; i < 40 && (n_wr - b_wr) < 1; i++) @(posedge clk);
        repeat (8) @(posedge clk);
        #1;
        checks += 5;
        if (n_wr - b_wr !== 1)          begin failures++; $display("FAIL atomic_wr_count: got %0d expected 1", n_wr - b_wr); end
        if (n_rd - b_rd !== 1)          begin failures++; $display("FAIL atomic_rd_count: got %0d expected 1", n_rd - b_rd); end
        if (wd_q.size() > b_wr && wd_q[b_wr] !== 8'h97) begin failures++; $display("FAIL atomic_data: got %h expected 97", wd_q[b_wr]); end
        if (vram_rd || vram_wr)         begin failures++; $display("FAIL atomic_hold_strobe: rd=%0b wr=%0b expected 0", vram_rd, vram_wr); end
        if (busy !== 1'b1)              begin failures++; $display("FAIL atomic_hold_busy: got %0b expected 1", busy); end
        super_res_drawing = 1'b0;
        wait_idle("atomic");
        checks += 2;
        if (n_wr - b_wr !== 2)          begin failures++; $display("FAIL atomic_second_count: got %0d expected 2", n_wr - b_wr); end
        if (wd_q.size() > b_wr + 1 && wd_q[b_wr + 1] !== 8'hCE) begin failures++; $display("FAIL atomic_second_data: got %h expected ce", wd_q[b_wr + 1]); end
    endtask

    task automatic test_reset_mid();
        logic seen = 1'b0;
        ext_reg_pixel_depth = 1'b0;
        ack_delay = 1000;
        push_req(10'd3, 10'd3, 8'h44);
        for (int i = 0; i < 10 && !seen; i++) begin
            if (vram_wr) seen = 1'b1;
            else begin @(posedge clk); #1; end
        end
        checks++;
        if (!seen) begin failures++; $display("FAIL rstmid_wr_rise: seen=0 expected 1"); end
        #2 reset_n = 1'b0;
        #1;
        checks += 4;
        if (vram_wr !== 1'b0)  begin failures++; $display("FAIL rstmid_wr: got %0b expected 0", vram_wr); end
        if (vram_rd !== 1'b0)  begin failures++; $display("FAIL rstmid_rd: got %0b expected 0", vram_rd); end
        if (busy !== 1'b0)     begin failures++; $display("FAIL rstmid_busy: got %0b expected 0", busy); end
        if (wr_ready !== 1'b0) begin failures++; $display("FAIL rstmid_ready: got %0b expected 0", wr_ready); end
        #2 reset_n = 1'b1;
        ack_delay = 1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        checks += 2;
        if (busy !== 1'b0)     begin failures++; $display("FAIL rstmid_empty: busy=%0b expected 0", busy); end
        if (vram_wr !== 1'b0)  begin failures++; $display("FAIL rstmid_after_wr: got %0b expected 0", vram_wr); end
    endtask

    task automatic test_disable();
        int b_strobe;
        ext_reg_pixel_depth = 1'b0;
        super_res_drawing = 1'b1;
        for (int i = 0; i < 3; i++) push_req(10'(i), 10'd5, 8'(8'h60 + i));
        checks++;
        if (busy !== 1'b1) begin failures++; $display("FAIL dis_queued_busy: got %0b expected 1", busy); end
        vdp_super = 1'b0;
        #1;
        checks++;
        if (wr_ready !== 1'b0) begin failures++; $display("FAIL dis_ready: got %0b expected 0", wr_ready); end
        @(posedge clk); #1;
        b_strobe = strobe_cycles;
        checks++;
        if (busy !== 1'b0) begin failures++; $display("FAIL dis_flush: busy=%0b expected 0", busy); end
        super_res_drawing = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        checks += 2;
        if (strobe_cycles !== b_strobe) begin failures++; $display("FAIL dis_strobes: got %0d cycles expected 0", strobe_cycles - b_strobe); end
        if (busy !== 1'b0)              begin failures++; $display("FAIL dis_idle: busy=%0b expected 0", busy); end
        vdp_super = 1'b1;
        #1;
        checks++;
        if (wr_ready !== 1'b1) begin failures++; $display("FAIL dis_reenable_ready: got %0b expected 1", wr_ready); end
    endtask

    initial begin
        vdp_super = 1'b1;
        super_res = 1'b1;
        super_mid = 1'b0;
        ext_reg_pixel_depth = 1'b0;
        ext_reg_super_res_page_addr = 17'h0;
        super_res_drawing = 1'b0;
        wr_valid = 1'b0;
        wr_x = '0;
        wr_y = '0;
        wr_data = '0;
        vram_rdata = '0;

        test_reset();
        test_8bpp();
        test_4bpp_rmw();
        test_mid_wrap();
        test_blocking();
        test_atomic();
        test_reset_mid();
        test_disable();

        checks++;
        if (both_cnt !== 0) begin failures++; $display("FAIL rd_wr_overlap: got %0d cycles expected 0", both_cnt); end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
